// File: rtl/layer_sequencer.sv
// Layer scheduler for the CNN engines: soft-resets, enables and waits on each
// engine in turn, flipping the SRAM ping-pong direction between layers.
module layer_sequencer #(
  parameter int unsigned NUM_LAYER = 3,
  parameter int unsigned TMO_W     = 16,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [TMO_W-1:0]     tmo_limit,
  input  logic [NUM_LAYER-1:0] layer_valid,
  output logic [NUM_LAYER-1:0] layer_enable,
  output logic [NUM_LAYER-1:0] layer_rst_n,
  output logic                 sram_sel,
  output logic [1:0]           cur_layer,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [1:0]       LAST_LAYER = 2'(NUM_LAYER - 1);
  localparam logic [2:0]       GAP_LOAD   = 3'(GAP_CYC - 1);
  localparam logic [TMO_W-1:0] WD_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_RUN, S_SWAP, S_GAP, S_DONE, S_ERR
  } state_e;

  state_e               state_q;
  logic [NUM_LAYER-1:0] enable_q;
  logic [NUM_LAYER-1:0] rst_n_q;
  logic                 sel_q;
  logic [1:0]           cur_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [TMO_W-1:0]     wd_q;
  logic [2:0]           gap_q;

  logic [NUM_LAYER-1:0] cur_oh;
  logic                 valid_cur;
  logic                 tmo_hit;

  // Only the valid of the engine in progress matters; others may be stale.
  assign cur_oh    = NUM_LAYER'(1) << cur_q;
  assign valid_cur = |(layer_valid & cur_oh);
  assign tmo_hit   = (tmo_limit != '0) && (wd_q == tmo_limit - TMO_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      enable_q <= '0;
      rst_n_q  <= '1;
      sel_q    <= 1'b0;
      cur_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
      gap_q    <= 3'd0;
    end else if (abort && (state_q != S_IDLE)) begin
      // Debug context (sram_sel, cur_layer, error) is deliberately kept.
      state_q  <= S_IDLE;
      enable_q <= '0;
      rst_n_q  <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q <= S_PREP;
            cur_q   <= 2'd0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            rst_n_q <= ~(NUM_LAYER'(1));
          end
        end
        S_PREP: begin
          state_q  <= S_RUN;
          rst_n_q  <= '1;
          enable_q <= cur_oh;
          wd_q     <= '0;
        end
        S_RUN: begin
          if (valid_cur) begin
            state_q  <= S_SWAP;
            enable_q <= '0;
            sel_q    <= ~sel_q;
          end else if (tmo_hit) begin
            state_q  <= S_ERR;
            enable_q <= '0;
            rst_n_q  <= ~cur_oh;
            busy_q   <= 1'b0;
            err_q    <= 1'b1;
          end else if (wd_q != WD_MAX) begin
            wd_q <= wd_q + TMO_W'(1);
          end
        end
        S_SWAP: begin
          if (cur_q == LAST_LAYER) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_GAP;
            cur_q   <= cur_q + 2'd1;
            gap_q   <= GAP_LOAD;
          end
        end
        S_GAP: begin
          if (gap_q == 3'd0) begin
            state_q <= S_PREP;
            rst_n_q <= ~cur_oh;
          end else begin
            gap_q <= gap_q - 3'd1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        S_ERR: begin
          state_q <= S_IDLE;
          rst_n_q <= '1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign layer_enable = enable_q;
  assign layer_rst_n  = rst_n_q;
  assign sram_sel     = sel_q;
  assign cur_layer    = cur_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: full run, stale valids, watchdog,
// abort in GAP, ignored start/valid, and asynchronous reset.
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] tmo_limit;
  logic [2:0]  lv;
  logic [2:0]  layer_enable;
  logic [2:0]  layer_rst_n;
  logic        sram_sel;
  logic [1:0]  cur_layer;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_err = 0;

  layer_sequencer #(.NUM_LAYER(3), .TMO_W(16), .GAP_CYC(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .tmo_limit    (tmo_limit),
    .layer_valid  (lv),
    .layer_enable (layer_enable),
    .layer_rst_n  (layer_rst_n),
    .sram_sel     (sram_sel),
    .cur_layer    (cur_layer),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] oh(input int i);
    return 3'(1 << i);
  endfunction

  // Advance to the next falling edge; a soft-reset engine drops its sticky valid.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) if (!layer_rst_n[i]) lv[i] = 1'b0;
  endtask

  // Raise valid for layer i (currently in RUN) and follow SWAP..next RUN or DONE.
  task automatic finish_layer(input int i, input logic exp_sel);
    logic [2:0] nxt;
    logic [2:0] nrst;
    nxt  = oh(i + 1);
    nrst = ~nxt;
    lv[i] = 1'b1;
    tick();
    chk("swap_en", layer_enable, 3'b000);
    chk("swap_sel", sram_sel, exp_sel);
    chk("swap_busy", busy, 1'b1);
    if (i == 2) begin
      tick();
      chk("done_pulse", done, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk("done_sel", sram_sel, exp_sel);
      tick();
      chk("done_clear", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end else begin
      tick();
      chk("gap_cur", cur_layer, i + 1);
      chk("gap_en", layer_enable, 3'b000);
      chk("gap_busy", busy, 1'b1);
      tick();
      chk("gap2_rstn", layer_rst_n, 3'b111);
      tick();
      chk("prep_rstn", layer_rst_n, nrst);
      chk("prep_en", layer_enable, 3'b000);
      tick();
      chk("run_en", layer_enable, nxt);
      chk("run_rstn", layer_rst_n, 3'b111);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tmo_limit = 16'd0; lv = 3'b000;

    // Reset values
    @(negedge clk);
    chk("rst_en", layer_enable, 3'b000);
    chk("rst_rstn", layer_rst_n, 3'b111);
    chk("rst_sel", sram_sel, 1'b0);
    chk("rst_cur", cur_layer, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", error, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_hold", busy, 1'b0);

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    chk("start_abort_rstn", layer_rst_n, 3'b111);

    // Full three-layer run, engines answer 10 cycles after enable
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_prep_busy", busy, 1'b1);
    chk("t1_prep_rstn", layer_rst_n, 3'b110);
    chk("t1_prep_en", layer_enable, 3'b000);
    tick();
    chk("t1_run_en", layer_enable, 3'b001);
    for (int i = 0; i < 3; i++) begin
      repeat (10) tick();
      chk("t1_hold_en", layer_enable, oh(i));
      chk("t1_hold_busy", busy, 1'b1);
      finish_layer(i, (i % 2) == 0);
    end
    chk("t1_err", error, 1'b0);

    // Stale valids from the previous run; start during RUN is ignored
    chk("t2_stale", lv, 3'b111);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_prep_rstn", layer_rst_n, 3'b110);
    chk("t2_prep_en", layer_enable, 3'b000);
    tick();
    chk("t2_run_en", layer_enable, 3'b001);
    chk("t2_run_rstn", layer_rst_n, 3'b111);
    tick();
    chk("t2_no_stale_accept", layer_enable, 3'b001);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_start_ign_en", layer_enable, 3'b001);
    chk("t5_start_ign_rstn", layer_rst_n, 3'b111);
    chk("t5_start_ign_cur", cur_layer, 2'd0);
    chk("t5_valid2_high", lv[2], 1'b1);
    tick();
    chk("t5_valid2_ign", layer_enable, 3'b001);
    finish_layer(0, 1'b1);
    repeat (3) tick();
    finish_layer(1, 1'b0);
    repeat (2) tick();
    finish_layer(2, 1'b1);

    // Watchdog: layer 1 never answers, limit 5
    tmo_limit = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    finish_layer(0, 1'b1);
    repeat (4) tick();
    chk("t3_still_run", layer_enable, 3'b010);
    tick();
    chk("t3_err", error, 1'b1);
    chk("t3_err_en", layer_enable, 3'b000);
    chk("t3_err_rstn", layer_rst_n, 3'b101);
    chk("t3_err_busy", busy, 1'b0);
    chk("t3_err_cur", cur_layer, 2'd1);
    chk("t3_err_done", done, 1'b0);
    tick();
    chk("t3_idle_err", error, 1'b1);
    chk("t3_idle_rstn", layer_rst_n, 3'b111);
    chk("t3_idle_done", done, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_restart_err", error, 1'b0);
    chk("t3_restart_cur", cur_layer, 2'd0);
    chk("t3_restart_sel", sram_sel, 1'b0);
    chk("t3_restart_rstn", layer_rst_n, 3'b110);
    tick();
    chk("t3_restart_en", layer_enable, 3'b001);

    // Abort during GAP after layer 0
    lv[0] = 1'b1;
    tick();
    tick();
    chk("t4_in_gap", cur_layer, 2'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_en", layer_enable, 3'b000);
    chk("t4_busy", busy, 1'b0);
    chk("t4_sel", sram_sel, 1'b1);
    chk("t4_cur", cur_layer, 2'd1);
    chk("t4_rstn", layer_rst_n, 3'b111);
    tick();
    chk("t4_stays_idle", layer_rst_n, 3'b111);

    // Asynchronous reset while layer 1 runs
    tmo_limit = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    finish_layer(0, 1'b1);
    chk("t6_pre_cur", cur_layer, 2'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_en", layer_enable, 3'b000);
    chk("t6_async_rstn", layer_rst_n, 3'b111);
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_sel", sram_sel, 1'b0);
    chk("t6_async_cur", cur_layer, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("t6_idle_busy", busy, 1'b0);
    chk("t6_idle_en", layer_enable, 3'b000);
    chk("t6_idle_rstn", layer_rst_n, 3'b111);
    chk("t6_idle_err", error, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
